des_key_sequencer: RTL and testbench

Iterative DES subkey generator. It replaces a fully unrolled 16-stage key schedule with one C/D register pair that is rotated once per accepted subkey. A key is loaded, PC1 is applied, and the block streams the 16 PC2 subkeys to the round engine over a valid/ready handshake. Order is K1..K16 for encryption and K16..K1 for decryption. It sits between the key input port and the iterative DES round datapath.

---
 rtl/des_pkg.sv | 46 ++++
 rtl/pc1.sv | 25 ++
 rtl/pc2.sv | 21 ++
 rtl/des_key_sequencer.sv | 116 +++++++++++
 tb/tb_des_key_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule tables, FSM state type and 28-bit C/D rotate helpers
package des_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  // Tables use the DES convention: entries are 1-based bit numbers counted from the MSB
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    logic [55:0] t;
    t = {x, x};
    return t[55 - int'(n) -: 28];
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [55:0] t;
    t = {x, x};
    return t[int'(n) +: 28];
  endfunction

endpackage

// File: rtl/pc1.sv
// rtl/pc1.sv - DES permuted choice 1: 64-bit key to 28-bit C0/D0 halves
module PC1
  import des_pkg::*;
(
  input  logic [63:0] key_i,
  output logic [27:0] c_o,
  output logic [27:0] d_o
);

  logic [55:0] cd;
  logic        unused_parity;

  always_comb begin
    cd = '0;
    for (int i = 0; i < 56; i++) cd[55-i] = key_i[64-PC1_TAB[i]];
  end

  // Parity bits never reach C/D
  assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                           key_i[24], key_i[16], key_i[8], key_i[0]};

  assign c_o = cd[55:28];
  assign d_o = cd[27:0];

endmodule

// File: rtl/pc2.sv
// rtl/pc2.sv - DES permuted choice 2: C/D register pair to 48-bit round subkey
module PC2
  import des_pkg::*;
(
  input  logic [27:0] c_i,
  input  logic [27:0] d_i,
  output logic [47:0] subkey_o
);

  logic [55:0] cd;
  logic        unused_bits;

  assign cd = {c_i, d_i};
  assign unused_bits = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < 48; i++) subkey_o[47-i] = cd[56-PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_sequencer.sv
// rtl/des_key_sequencer.sv - iterative DES subkey streamer (K1..K16 or K16..K1)
// Optional odd-parity key check under `DES_KEYSEQ_PARITY_CHECK_EN.
module des_key_sequencer
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        load,
  output logic        load_ready,
  output logic [47:0] subkey,
  output logic [3:0]  sk_round,
  output logic        sk_last,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic        busy,
  output logic        key_err
);

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [27:0] pc1_c, pc1_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        dec_q, dec_d;
  logic        err_q, err_d;
  logic        key_bad;
  logic        last;

  PC1 u_pc1 (.key_i(key_in), .c_o(pc1_c), .d_o(pc1_d));
  PC2 u_pc2 (.c_i(c_q), .d_i(d_q), .subkey_o(subkey));

`ifdef DES_KEYSEQ_PARITY_CHECK_EN
  always_comb begin
    key_bad = 1'b0;
    for (int b = 0; b < 8; b++) if (!(^key_in[8*b +: 8])) key_bad = 1'b1;
  end
`else
  assign key_bad = 1'b0;
`endif

  // rnd_q holds round-1, so it doubles as the sk_round output
  assign last = dec_q ? (rnd_q == 4'd0) : (rnd_q == 4'd15);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    rnd_d   = rnd_q;
    dec_d   = dec_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          if (key_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            dec_d   = decrypt;
            if (decrypt) begin
              c_d   = pc1_c;
              d_d   = pc1_d;
              rnd_d = 4'd15;
            end else begin
              c_d   = rotl28(pc1_c, 2'd1);
              d_d   = rotl28(pc1_d, 2'd1);
              rnd_d = 4'd0;
            end
          end
        end
      end
      ST_RUN: begin
        if (sk_ready) begin
          if (last) begin
            state_d = ST_IDLE;
          end else if (dec_q) begin
            c_d   = rotr28(c_q, SHIFT_TAB[rnd_q]);
            d_d   = rotr28(d_q, SHIFT_TAB[rnd_q]);
            rnd_d = rnd_q - 4'd1;
          end else begin
            c_d   = rotl28(c_q, SHIFT_TAB[rnd_q + 4'd1]);
            d_d   = rotl28(d_q, SHIFT_TAB[rnd_q + 4'd1]);
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      rnd_q   <= '0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      rnd_q   <= rnd_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign sk_valid   = (state_q == ST_RUN);
  assign busy       = sk_valid;
  assign sk_round   = rnd_q;
  assign sk_last    = sk_valid && last;
  assign key_err    = err_q;

endmodule

// File: tb/tb_des_key_sequencer.sv
// tb/tb_des_key_sequencer.sv - randomized self-checking bench against a full-schedule DES key model
module tb_des_key_sequencer;

  logic        clk = 1'b0;
  logic        rst, load, decrypt, sk_ready;
  logic [63:0] key_in;
  logic        load_ready, sk_last, sk_valid, busy, key_err;
  logic [47:0] subkey;
  logic [3:0]  sk_round;

  int n_pass = 0;
  int n_checks = 0;

  int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] ks [1:16];

  des_key_sequencer dut (
    .clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt), .load(load),
    .load_ready(load_ready), .subkey(subkey), .sk_round(sk_round), .sk_last(sk_last),
    .sk_valid(sk_valid), .sk_ready(sk_ready), .busy(busy), .key_err(key_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] rol(input logic [27:0] x, input int s);
    if (s == 0) return x;
    return (x << s) | (x >> (28 - s));
  endfunction

  // Each Kr is C0/D0 rotated by the cumulative shift count, not by stepping
  task automatic build_schedule(input logic [63:0] key);
    logic [55:0] cd0, cd;
    int tot;
    for (int i = 0; i < 56; i++) cd0[55-i] = key[64-PC1_T[i]];
    tot = 0;
    for (int r = 1; r <= 16; r++) begin
      tot += SHIFT[r-1];
      cd = {rol(cd0[55:28], tot % 28), rol(cd0[27:0], tot % 28)};
      for (int j = 0; j < 48; j++) ks[r][47-j] = cd[56-PC2_T[j]];
    end
  endtask

  function automatic bit parity_ok(input logic [63:0] k);
    for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int b = 0; b < 8; b++) if (!(^r[8*b +: 8])) r[8*b] = ~r[8*b];
    return r;
  endfunction

  // mode 0: sk_ready high; 1: random stalls; 2: stall_len cycles when round stall_rnd is shown
  task automatic run_seq(input logic [63:0] key, input bit dec, input int mode,
                         input int stall_rnd, input int stall_len, output int cycles,
                         output logic [47:0] first_sk, output logic [47:0] last_sk,
                         output logic [3:0] last_rnd);
    bit expect_err;
    bit ready;
    int j, r, stalled, streak;
`ifdef DES_KEYSEQ_PARITY_CHECK_EN
    expect_err = !parity_ok(key);
`else
    expect_err = 1'b0;
`endif
    build_schedule(key);
    cycles = 0; first_sk = '0; last_sk = '0; last_rnd = '0;
    check("load_ready_before_load", load_ready, 1);
    key_in = key; decrypt = dec; load = 1'b1; sk_ready = 1'b1;
    step();
    load = 1'b0; key_in = {$urandom, $urandom}; decrypt = 1'($urandom);
    if (expect_err) begin
      check("key_err_pulse", key_err, 1);
      check("err_no_valid", sk_valid, 0);
      check("err_load_ready", load_ready, 1);
      step();
      check("key_err_clears", key_err, 0);
      check("err_still_idle", sk_valid, 0);
      return;
    end
    check("key_err_quiet", key_err, 0);
    j = 0; stalled = 0; streak = 0;
    while (j < 16 && cycles < 200) begin
      r = dec ? 16 - j : j + 1;
      check("sk_valid", sk_valid, 1);
      check("subkey", subkey, ks[r]);
      check("sk_round", sk_round, 64'(r - 1));
      check("sk_last", sk_last, (j == 15));
      check("busy", busy, 1);
      check("load_ready_run", load_ready, 0);
      if (j == 0) first_sk = subkey;
      last_sk = subkey; last_rnd = sk_round;
      case (mode)
        1:       ready = ($urandom_range(3) != 0) || (streak >= 3);
        2:       ready = !(r == stall_rnd && stalled < stall_len);
        default: ready = 1'b1;
      endcase
      if (!ready) begin stalled++; streak++; end else streak = 0;
      sk_ready = ready;
      load = 1'($urandom); key_in = {$urandom, $urandom}; decrypt = 1'($urandom);
      step();
      cycles++;
      if (ready) j++;
    end
    load = 1'b0; sk_ready = 1'b1;
    check("seq_complete", j, 16);
    check("idle_valid", sk_valid, 0);
    check("idle_load_ready", load_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_last", sk_last, 0);
  endtask

  initial begin
    int cyc;
    logic [47:0] fsk, lsk;
    logic [3:0] lrn;
    logic [63:0] k;

    rst = 1'b1; load = 1'b0; decrypt = 1'b0; sk_ready = 1'b0; key_in = '0;
    step(); step();
    check("rst_load_ready", load_ready, 1);
    check("rst_sk_valid", sk_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_subkey", subkey, 0);
    check("rst_sk_round", sk_round, 0);
    check("rst_sk_last", sk_last, 0);
    check("rst_key_err", key_err, 0);
    rst = 1'b0;
    step();

    run_seq(64'h133457799BBCDFF1, 1'b0, 0, 0, 0, cyc, fsk, lsk, lrn);
    check("enc_K1", fsk, 48'h1B02EFFC7072);
    check("enc_K16", lsk, 48'hCB3D8B0E17F5);
    check("enc_cycles", cyc, 16);

    run_seq(64'h133457799BBCDFF1, 1'b1, 0, 0, 0, cyc, fsk, lsk, lrn);
    check("dec_first", fsk, 48'hCB3D8B0E17F5);
    check("dec_last", lsk, 48'h1B02EFFC7072);
    check("dec_last_round", lrn, 0);

    run_seq(64'h133457799BBCDFF1, 1'b0, 2, 9, 3, cyc, fsk, lsk, lrn);
    check("bp_cycles", cyc, 19);
    check("bp_K16", lsk, 48'hCB3D8B0E17F5);

    build_schedule(64'h133457799BBCDFF1);
    key_in = 64'h133457799BBCDFF1; decrypt = 1'b0; load = 1'b1; sk_ready = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_round", sk_round, 4);
    check("pre_rst_subkey", subkey, ks[5]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", sk_valid, 0);
    check("midrst_load_ready", load_ready, 1);
    check("midrst_subkey", subkey, 0);
    check("midrst_round", sk_round, 0);
    step();
    check("midrst_no_last", sk_last, 0);
    check("midrst_stays_idle", sk_valid, 0);

    run_seq(64'h133457799BBCDFF0, 1'b0, 0, 0, 0, cyc, fsk, lsk, lrn);
`ifndef DES_KEYSEQ_PARITY_CHECK_EN
    check("noparity_K1", fsk, 48'h1B02EFFC7072);
    check("noparity_K16", lsk, 48'hCB3D8B0E17F5);
`endif
    run_seq(64'h133457799BBCDFF1, 1'b0, 0, 0, 0, cyc, fsk, lsk, lrn);
    check("after_err_K1", fsk, 48'h1B02EFFC7072);

    for (int n = 0; n < 24; n++) begin
      k = {$urandom, $urandom};
      if ($urandom_range(1) == 1) k = fix_parity(k);
      run_seq(k, 1'($urandom), 1, 0, 0, cyc, fsk, lsk, lrn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
